irda_frame_sequencer: RTL and testbench

//  Parametrised successor to the fixed 12-bit TX bit counter. Times one IrDA TX frame:

---
 rtl/irda_pkg.sv | 14 +
 rtl/irda_mod_counter.sv | 38 +++
 rtl/irda_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_irda_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/irda_pkg.sv
// rtl/irda_pkg.sv - shared state type and parameter defaults for the IrDA frame sequencer
package irda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int PULSE_LEN_DEF  = 3;
  localparam int MAX_BITS_DEF   = 12;

endpackage

// File: rtl/irda_mod_counter.sv
// rtl/irda_mod_counter.sv - modulo counter with run-time terminal value and wrap pulse
module irda_mod_counter #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Wrap is combinational so the owner can act on the same edge the counter returns to 0.
  assign wrap_o  = en_i && (count_q == term_i);
  assign count_o = count_q;

  // Next count: clear wins, then wrap to zero at the terminal value, else increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/irda_frame_sequencer.sv
// rtl/irda_frame_sequencer.sv - times one IrDA TX frame in baud ticks and bits
module irda_frame_sequencer
  import irda_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PULSE_LEN  = PULSE_LEN_DEF,
  parameter int MAX_BITS   = MAX_BITS_DEF,
  parameter int CW         = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          tick,
  input  logic          start,
  input  logic [CW-1:0] frame_len,
  output logic [CW-1:0] bit_idx,
  output logic          bit_strobe,
  output logic          pulse_win,
  output logic          busy,
  output logic          frame_done
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SUB_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] PULSE_LIM  = SW'(PULSE_LEN);
  localparam logic [CW-1:0] MAX_BITS_W = CW'(MAX_BITS);

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          rst_all;
  logic          sub_en;
  logic          sub_wrap;
  logic [SW-1:0] sub_cnt;
  logic          bit_wrap;
  logic [CW-1:0] bit_term;

  assign rst_all  = reset | clear;
  assign sub_en   = (state_q == RUN) && tick;
  // len_q is at least 1 whenever the bit counter is enabled, so len_q-1 never underflows in use.
  assign bit_term = len_q - 1'b1;

  irda_mod_counter #(
    .N (OVERSAMPLE),
    .W (SW)
  ) u_sub_cnt (
    .clk     (clk),
    .clr_i   (rst_all),
    .en_i    (sub_en),
    .term_i  (SUB_LAST),
    .count_o (sub_cnt),
    .wrap_o  (sub_wrap)
  );

  irda_mod_counter #(
    .N (MAX_BITS),
    .W (CW)
  ) u_bit_cnt (
    .clk     (clk),
    .clr_i   (rst_all),
    .en_i    (sub_wrap),
    .term_i  (bit_term),
    .count_o (bit_idx),
    .wrap_o  (bit_wrap)
  );

  // Next state, frame length latch and registered output values.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    strobe_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d = RUN;
          len_d   = (frame_len > MAX_BITS_W) ? MAX_BITS_W : frame_len;
        end
      end
      RUN: begin
        strobe_d = sub_wrap;
        if (bit_wrap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  // State and output registers; reset and clear abort silently.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q  <= IDLE;
      len_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bit_strobe = strobe_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign pulse_win  = busy_q && (sub_cnt < PULSE_LIM);

endmodule

// File: tb/tb_irda_frame_sequencer.sv
// tb/tb_irda_frame_sequencer.sv - self-checking bench for irda_frame_sequencer
module tb_irda_frame_sequencer;

  localparam int OS = 16;
  localparam int PL = 3;
  localparam int MB = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, clear, tick, start;
  logic [CW-1:0] frame_len;
  logic [CW-1:0] bit_idx;
  logic          bit_strobe, pulse_win, busy, frame_done;

  always #5 clk = ~clk;

  irda_frame_sequencer #(
    .OVERSAMPLE (OS),
    .PULSE_LEN  (PL),
    .MAX_BITS   (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .tick       (tick),
    .start      (start),
    .frame_len  (frame_len),
    .bit_idx    (bit_idx),
    .bit_strobe (bit_strobe),
    .pulse_win  (pulse_win),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is "active" while fewer than len*OS ticks have been consumed.
  bit m_active = 1'b0;
  bit m_gap    = 1'b0;
  int m_t      = 0;
  int m_len    = 0;
  bit m_strobe = 1'b0;
  bit m_done   = 1'b0;

  int n_strobe, n_done, n_busy_ticks, n_pulse_ticks, n_coinc, cyc;

  task automatic model_edge();
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (reset || clear) begin
      m_active = 1'b0;
      m_gap    = 1'b0;
      m_t      = 0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_active) begin
      if (tick) begin
        m_t++;
        if (m_t % OS == 0) m_strobe = 1'b1;
        if (m_t == m_len * OS) begin
          m_active = 1'b0;
          m_t      = 0;
          m_gap    = 1'b1;
          m_done   = 1'b1;
        end
      end
    end else if (start && frame_len != 0) begin
      m_active = 1'b1;
      m_t      = 0;
      m_len    = (int'(frame_len) > MB) ? MB : int'(frame_len);
    end
  endtask

  task automatic step();
    if (busy && tick) n_busy_ticks++;
    if (pulse_win && tick) n_pulse_ticks++;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("busy", int'(busy), int'(m_active));
    check_eq("bit_idx", int'(bit_idx), m_active ? m_t / OS : 0);
    check_eq("pulse_win", int'(pulse_win), int'(m_active && (m_t % OS) < PL));
    check_eq("bit_strobe", int'(bit_strobe), int'(m_strobe));
    check_eq("frame_done", int'(frame_done), int'(m_done));
    if (bit_strobe) n_strobe++;
    if (frame_done) n_done++;
    if (bit_strobe && frame_done) n_coinc++;
  endtask

  task automatic clr_counts();
    n_strobe = 0; n_done = 0; n_busy_ticks = 0; n_pulse_ticks = 0; n_coinc = 0;
  endtask

  task automatic start_frame(input int len);
    frame_len = CW'(len);
    start = 1'b1;
    tick  = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic finish_frame(input int period, input int budget);
    int k = 0;
    while ((m_active || m_gap) && k < budget) begin
      tick = ((k % period) == period - 1);
      step();
      k++;
    end
    tick = 1'b0;
    check_eq("frame_timeout", int'(m_active || m_gap), 0);
  endtask

  int t_done, t_rise;
  bit prev_busy;

  initial begin
    reset = 1'b1; clear = 1'b0; tick = 1'b0; start = 1'b0; frame_len = '0;
    cyc = 0;
    clr_counts();
    step();
    step();
    reset = 1'b0;
    step();

    // 1: reset in the middle of a 12-bit frame
    clr_counts();
    start_frame(12);
    tick = 1'b1;
    repeat (40) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();
    tick = 1'b0;
    check_eq("s1_no_done", n_done, 0);

    // 2: nominal 12-bit frame with continuous tick
    clr_counts();
    start_frame(12);
    finish_frame(1, 400);
    check_eq("s2_strobes", n_strobe, 12);
    check_eq("s2_done", n_done, 1);
    check_eq("s2_coinc", n_coinc, 1);
    check_eq("s2_busy_ticks", n_busy_ticks, 192);
    check_eq("s2_pulse_ticks", n_pulse_ticks, 36);

    // 3: edge lengths 0, 15 (clamped) and 1
    clr_counts();
    frame_len = '0; start = 1'b1; tick = 1'b1;
    repeat (6) step();
    start = 1'b0; tick = 1'b0;
    check_eq("s3_len0_done", n_done, 0);
    check_eq("s3_len0_ticks", n_busy_ticks, 0);
    clr_counts();
    start_frame(15);
    finish_frame(1, 400);
    check_eq("s3_len15_strobes", n_strobe, 12);
    clr_counts();
    start_frame(1);
    finish_frame(1, 100);
    check_eq("s3_len1_strobes", n_strobe, 1);
    check_eq("s3_len1_done", n_done, 1);
    check_eq("s3_len1_ticks", n_busy_ticks, 16);
    step();

    // 4: sparse tick, start held high across frames
    clr_counts();
    frame_len = CW'(3); start = 1'b1;
    t_done = -1; t_rise = -1; prev_busy = busy;
    for (int k = 0; k < 2000 && n_done < 2; k++) begin
      tick = ((k % 5) == 4);
      step();
      if (frame_done && t_done < 0) t_done = cyc;
      if (t_done >= 0 && t_rise < 0 && busy && !prev_busy) t_rise = cyc;
      prev_busy = busy;
    end
    start = 1'b0; tick = 1'b0;
    check_eq("s4_done_count", n_done, 2);
    check_eq("s4_restart_gap", t_rise - t_done, 2);
    check_eq("s4_busy_ticks", n_busy_ticks, 96);
    step();

    // 5: clear on the final tick of the frame
    clr_counts();
    start_frame(2);
    tick = 1'b1;
    for (int k = 0; k < 100 && m_t < 2 * OS - 1; k++) step();
    clear = 1'b1;
    step();
    clear = 1'b0; tick = 1'b0;
    repeat (3) step();
    check_eq("s5_strobes", n_strobe, 1);
    check_eq("s5_done", n_done, 0);

    // 6: frame_len changed mid-frame
    clr_counts();
    start_frame(3);
    frame_len = CW'(7);
    finish_frame(1, 400);
    check_eq("s6_first_strobes", n_strobe, 3);
    step();
    clr_counts();
    start = 1'b1;
    step();
    start = 1'b0;
    finish_frame(1, 400);
    check_eq("s6_second_strobes", n_strobe, 7);

    // 7: random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      tick      = ($urandom % 3) == 0;
      start     = ($urandom % 4) == 0;
      frame_len = CW'($urandom_range(0, 15));
      clear     = ($urandom % 300) == 0;
      reset     = ($urandom % 700) == 0;
      step();
    end
    reset = 1'b0; clear = 1'b0; tick = 1'b0; start = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
